// File: rtl/reg_set_pkg.sv
// Shared types for the register-set write path: default widths, request record, issue FSM states.
// Optional macro REG_WR_COALESCE_EN (consumed by reg_wr_buffer) merges same-address back-to-back writes.
package reg_set_pkg;

  localparam int unsigned N_DEF = 8;
  localparam int unsigned W_DEF = 3;

  typedef struct packed {
    logic [W_DEF-1:0] addr;
    logic [N_DEF-1:0] data;
  } wr_req_t;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage

// File: rtl/wr_req_fifo.sv
// Synchronous FIFO of write requests, single-cycle push/pop, exact occupancy count, tail-entry rewrite port.
// Caller guarantees no push when full and no pop when empty; no internal backpressure.
module wr_req_fifo
  import reg_set_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type T = wr_req_t,
  localparam int unsigned PW = $clog2(DEPTH),
  localparam int unsigned CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_vld,
  input  T              push_dat,
  input  logic          pop_vld,
  input  logic          tail_wr_vld,
  input  T              tail_wr_dat,
  output T              head_dat,
  output T              tail_dat,
  output logic [CW-1:0] count
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] tail_ptr;
  T              mem_q [DEPTH];
  T              mem_d [DEPTH];

  // Tail is the slot most recently written by a push.
  assign tail_ptr = wr_ptr_q - PW'(1);
  assign head_dat = mem_q[rd_ptr_q];
  assign tail_dat = mem_q[tail_ptr];
  assign count    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_vld) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (tail_wr_vld) begin
      mem_d[tail_ptr] = tail_wr_dat;
    end
    if (pop_vld) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_vld, pop_vld})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/reg_wr_buffer.sv
// Buffers (addr,data) writes and issues one per cycle to the register set; pushed at edge k -> rf_wen after k+1.
// in_ready drops only when full; rf_busy stalls issue and holds rf_wr_addr/rf_d. Macro REG_WR_COALESCE_EN merges tail writes.
module reg_wr_buffer
  import reg_set_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned w     = W_DEF,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [w-1:0]             in_addr,
  input  logic [N-1:0]             in_data,
  input  logic                     rf_busy,
  output logic                     rf_wen,
  output logic [w-1:0]             rf_wr_addr,
  output logic [N-1:0]             rf_d,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [w-1:0] addr;
    logic [N-1:0] data;
  } req_t;

  state_e         state_q, state_d;
  logic           rf_wen_q, rf_wen_d;
  logic [w-1:0]   rf_wr_addr_q, rf_wr_addr_d;
  logic [N-1:0]   rf_d_q, rf_d_d;

  logic           push_acc;
  logic           pop;
  logic           coalesce;
  req_t           in_req;
  req_t           head_dat;
  req_t           tail_dat;
  logic [CW-1:0]  fifo_count;

  assign in_req   = '{addr: in_addr, data: in_data};
  assign in_ready = (fifo_count != CW'(DEPTH));
  assign push_acc = in_valid && in_ready;
  assign pop      = (state_q == ISSUE) && (fifo_count != '0) && !rf_busy;

`ifdef REG_WR_COALESCE_EN
  // A lone entry that is popping this cycle is already gone, so it cannot absorb the write.
  assign coalesce = push_acc && (fifo_count != '0) && (tail_dat.addr == in_addr)
                    && !(pop && (fifo_count == CW'(1)));
`else
  assign coalesce = 1'b0;
`endif

  wr_req_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_vld    (push_acc && !coalesce),
    .push_dat    (in_req),
    .pop_vld     (pop),
    .tail_wr_vld (coalesce),
    .tail_wr_dat (in_req),
    .head_dat    (head_dat),
    .tail_dat    (tail_dat),
    .count       (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (push_acc) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (pop && (fifo_count == CW'(1)) && !push_acc) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rf_wen_d     = pop;
    rf_wr_addr_d = rf_wr_addr_q;
    rf_d_d       = rf_d_q;
    if (pop) begin
      rf_wr_addr_d = head_dat.addr;
      rf_d_d       = head_dat.data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rf_wen_q     <= 1'b0;
      rf_wr_addr_q <= '0;
      rf_d_q       <= '0;
    end else begin
      state_q      <= state_d;
      rf_wen_q     <= rf_wen_d;
      rf_wr_addr_q <= rf_wr_addr_d;
      rf_d_q       <= rf_d_d;
    end
  end

  assign rf_wen     = rf_wen_q;
  assign rf_wr_addr = rf_wr_addr_q;
  assign rf_d       = rf_d_q;
  assign count      = fifo_count;

endmodule

// File: tb/tb_reg_wr_buffer.sv
// Bench for reg_wr_buffer: directed scenarios plus random traffic against a queue-based reference model.
// Honours REG_WR_COALESCE_EN the same way as the design.
module tb_reg_wr_buffer;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_addr;
  logic [7:0] in_data;
  logic       rf_busy;
  logic       rf_wen;
  logic [2:0] rf_wr_addr;
  logic [7:0] rf_d;
  logic [2:0] count;

  reg_wr_buffer #(.N(8), .w(3), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .rf_busy    (rf_busy),
    .rf_wen     (rf_wen),
    .rf_wr_addr (rf_wr_addr),
    .rf_d       (rf_d),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic [7:0] d;
  } ent_t;

  ent_t       q[$];
  logic       exp_wen;
  logic [2:0] exp_addr;
  logic [7:0] exp_d;
  int         n_tests;
  int         n_fail;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".rf_wen"},   32'(rf_wen),     32'(exp_wen));
    check_eq({ctx, ".rf_addr"},  32'(rf_wr_addr), 32'(exp_addr));
    check_eq({ctx, ".rf_d"},     32'(rf_d),       32'(exp_d));
    check_eq({ctx, ".count"},    32'(count),      32'(q.size()));
    check_eq({ctx, ".in_ready"}, 32'(in_ready),   32'(q.size() != DEPTH));
  endtask

  // Reference: a queue is the buffer; each cycle at most one head entry leaves when not busy.
  task automatic model_cycle(input logic v, input logic [2:0] a, input logic [7:0] d, input logic busy);
    int   sz;
    bit   do_pop;
    bit   do_push;
    bit   coal;
    ent_t e;
    sz      = q.size();
    do_pop  = (sz != 0) && !busy;
    do_push = v && (sz != DEPTH);
    coal    = 1'b0;
`ifdef REG_WR_COALESCE_EN
    coal = do_push && (sz != 0) && (q[sz-1].a == a) && !(do_pop && sz == 1);
`endif
    if (do_pop) begin
      e        = q.pop_front();
      exp_wen  = 1'b1;
      exp_addr = e.a;
      exp_d    = e.d;
    end else begin
      exp_wen = 1'b0;
    end
    if (do_push) begin
      if (coal) begin
        e   = q[q.size()-1];
        e.d = d;
        q[q.size()-1] = e;
      end else begin
        e.a = a;
        e.d = d;
        q.push_back(e);
      end
    end
  endtask

  task automatic step(input string ctx, input logic v, input logic [2:0] a,
                      input logic [7:0] d, input logic busy);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    rf_busy  = busy;
    model_cycle(v, a, d, busy);
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  task automatic idle_steps(input string ctx, input int n, input logic busy);
    for (int i = 0; i < n; i++) step(ctx, 1'b0, 3'd0, 8'd0, busy);
  endtask

  task automatic async_reset(input string ctx);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    q.delete();
    exp_wen  = 1'b0;
    exp_addr = '0;
    exp_d    = '0;
    check_all({ctx, ".imm"});
    @(posedge clk);
    #1;
    check_all({ctx, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = '0;
    in_data  = '0;
    rf_busy  = 1'b0;
    exp_wen  = 1'b0;
    exp_addr = '0;
    exp_d    = '0;
    @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Single write: issued one cycle after the push edge.
    step("single.push", 1'b1, 3'd1, 8'h0F, 1'b0);
    step("single.issue", 1'b0, 3'd0, 8'h00, 1'b0);
    check_eq("single.wen_hi", 32'(rf_wen), 32'd1);
    check_eq("single.d", 32'(rf_d), 32'h0F);
    step("single.after", 1'b0, 3'd0, 8'h00, 1'b0);
    check_eq("single.wen_lo", 32'(rf_wen), 32'd0);

    // Burst to full while busy, then drain in order.
    for (int i = 0; i < 4; i++) step("burst.fill", 1'b1, 3'(i), 8'(8'h10 + i), 1'b1);
    check_eq("burst.count_full", 32'(count), 32'd4);
    check_eq("burst.ready_low", 32'(in_ready), 32'd0);
    step("burst.refused", 1'b1, 3'd7, 8'hEE, 1'b1);
    idle_steps("burst.drain", 5, 1'b0);

    // Stall for two cycles after the first issue.
    for (int i = 0; i < 3; i++) step("stall.fill", 1'b1, 3'(5 + i), 8'(8'hA0 + i), 1'b1);
    step("stall.first", 1'b0, 3'd0, 8'd0, 1'b0);
    idle_steps("stall.busy", 2, 1'b1);
    idle_steps("stall.drain", 4, 1'b0);

    // Push while popping at count 2.
    step("pp.fill", 1'b1, 3'd2, 8'h21, 1'b1);
    step("pp.fill", 1'b1, 3'd4, 8'h22, 1'b1);
    step("pp.both", 1'b1, 3'd6, 8'h23, 1'b0);
    check_eq("pp.count_stays", 32'(count), 32'd2);
    idle_steps("pp.drain", 4, 1'b0);

    // Async reset with entries queued; nothing stale may issue afterwards.
    for (int i = 0; i < 3; i++) step("rst.fill", 1'b1, 3'(i + 1), 8'(8'h50 + i), 1'b1);
    step("rst.pop1", 1'b0, 3'd0, 8'd0, 1'b0);
    async_reset("rst");
    idle_steps("rst.after", 4, 1'b0);

    // Same-address pair: merged when coalescing is built in, two writes otherwise.
    step("coal.a", 1'b1, 3'd3, 8'h33, 1'b1);
    step("coal.b", 1'b1, 3'd3, 8'h70, 1'b1);
`ifdef REG_WR_COALESCE_EN
    check_eq("coal.count", 32'(count), 32'd1);
`else
    check_eq("coal.count", 32'(count), 32'd2);
`endif
    idle_steps("coal.drain", 3, 1'b0);

    // Random traffic; narrow address range makes repeated addresses common.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 99) < 70),
           3'($urandom_range(0, 3)),
           8'($urandom),
           1'($urandom_range(0, 99) < 30));
      if (i == 200) async_reset("rand.rst");
    end
    idle_steps("final.drain", 6, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
